// File: rtl/kbdmus_latch_if.sv
// Bus bundle between the AVR SPI keyboard/mouse front end, the Z80 port decoder
// and the kbdmus_latch consumer.
interface kbdmus_latch_if;
   logic [39:0] kbd_in;
   logic        kbd_stb;
   logic [7:0]  mus_in;
   logic        mus_xstb;
   logic        mus_ystb;
   logic        mus_btnstb;
   logic        kj_stb;
   logic [7:0]  zah;
   logic        fe_rd_stb;
   logic        int_stb;
   logic [4:0]  kbd_data;
   logic [7:0]  mus_xdata;
   logic [7:0]  mus_ydata;
   logic [7:0]  mus_btns;
   logic [7:0]  kj_data;

   modport master (
      output kbd_in, kbd_stb, mus_in, mus_xstb, mus_ystb, mus_btnstb,
      output kj_stb, zah, fe_rd_stb, int_stb,
      input  kbd_data, mus_xdata, mus_ydata, mus_btns, kj_data
   );

   modport slave (
      input  kbd_in, kbd_stb, mus_in, mus_xstb, mus_ystb, mus_btnstb,
      input  kj_stb, zah, fe_rd_stb, int_stb,
      output kbd_data, mus_xdata, mus_ydata, mus_btns, kj_data
   );
endinterface

// File: rtl/kbdmus_latch.sv
// Keyboard matrix / Kempston mouse / joystick latch serving Z80 port reads.
// Define KBD_STICKY_EN to hold short key taps until scanned (or aged out).
module kbdmus_latch #(
   parameter int STICKY_FRAMES = 3
) (
   input logic           fclk,
   input logic           rst_n,
   kbdmus_latch_if.slave bus
);

   logic [39:0] mat_q, mat_d;
   logic [39:0] eff;
   logic [4:0]  kbd_q, kbd_d;
   logic [7:0]  musx_q, musx_d;
   logic [7:0]  musy_q, musy_d;
   logic [7:0]  btn_q, btn_d;
   logic [7:0]  kj_q, kj_d;
   logic [4:0]  row_or;

   always_comb begin
      mat_d  = bus.kbd_stb    ? bus.kbd_in : mat_q;
      musx_d = bus.mus_xstb   ? bus.mus_in : musx_q;
      musy_d = bus.mus_ystb   ? bus.mus_in : musy_q;
      btn_d  = bus.mus_btnstb ? bus.mus_in : btn_q;
      kj_d   = bus.kj_stb     ? bus.mus_in : kj_q;
   end

   always_comb begin
      row_or = '0;
      for (int r = 0; r < 8; r++) begin
         if (!bus.zah[r]) row_or = row_or | eff[5*r +: 5];
      end
      kbd_d = ~row_or;
   end

`ifdef KBD_STICKY_EN
   localparam logic [2:0] AGE_MAX = 3'(STICKY_FRAMES);

   logic [39:0]      stk_q, stk_d;
   logic [39:0]      set_m, clr_m;
   logic [7:0][2:0]  age_q, age_d;

   // Clear decisions look at the matrix being loaded this cycle, so a key
   // that is pressed in the new matrix can never be dropped.
   always_comb begin
      set_m = bus.kbd_stb ? bus.kbd_in : '0;
      clr_m = '0;
      age_d = age_q;
      for (int r = 0; r < 8; r++) begin
         if ((bus.fe_rd_stb && !bus.zah[r]) || age_q[r] == AGE_MAX)
            clr_m[5*r +: 5] = ~mat_d[5*r +: 5];
         if (|set_m[5*r +: 5])
            age_d[r] = '0;
         else if (bus.int_stb && age_q[r] != AGE_MAX)
            age_d[r] = age_q[r] + 3'd1;
      end
      stk_d = (stk_q & ~clr_m) | set_m;
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         stk_q <= '0;
         age_q <= '0;
      end else begin
         stk_q <= stk_d;
         age_q <= age_d;
      end
   end

   assign eff = mat_q | stk_q;
`else
   logic unused_sticky;
   assign unused_sticky = ^{bus.fe_rd_stb, bus.int_stb, 32'(STICKY_FRAMES)};
   assign eff = mat_q;
`endif

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         mat_q  <= '0;
         kbd_q  <= 5'h1F;
         musx_q <= 8'h00;
         musy_q <= 8'h00;
         btn_q  <= 8'hFF;
         kj_q   <= 8'h00;
      end else begin
         mat_q  <= mat_d;
         kbd_q  <= kbd_d;
         musx_q <= musx_d;
         musy_q <= musy_d;
         btn_q  <= btn_d;
         kj_q   <= kj_d;
      end
   end

   assign bus.kbd_data  = kbd_q;
   assign bus.mus_xdata = musx_q;
   assign bus.mus_ydata = musy_q;
   assign bus.mus_btns  = btn_q;
   assign bus.kj_data   = kj_q;

endmodule

// File: tb/tb_kbdmus_latch.sv
// Self-checking bench for kbdmus_latch: directed scenarios plus random traffic
// checked against a per-key behavioural model.
module tb_kbdmus_latch;

`ifdef KBD_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif
   localparam int SF = 3;

   logic fclk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   kbdmus_latch_if bus();

   kbdmus_latch #(.STICKY_FRAMES(SF)) dut (
      .fclk  (fclk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 fclk = ~fclk;

   // behavioural model state
   bit [39:0] m_mat, m_stk;
   int        m_age[8];
   bit [4:0]  m_kbd;
   bit [7:0]  m_x, m_y, m_b, m_j;

   task automatic model_reset();
      m_mat = '0;
      m_stk = '0;
      for (int r = 0; r < 8; r++) m_age[r] = 0;
      m_kbd = 5'h1F;
      m_x = 8'h00; m_y = 8'h00; m_b = 8'hFF; m_j = 8'h00;
   endtask

   task automatic model_step();
      bit [39:0] nm, ns;
      bit [4:0]  nk;
      int        na[8];
      nk = 5'h1F;
      for (int k = 0; k < 40; k++)
         if (!bus.zah[k/5] && (m_mat[k] || m_stk[k])) nk[k%5] = 1'b0;
      nm = bus.kbd_stb ? bus.kbd_in : m_mat;
      ns = '0;
      for (int r = 0; r < 8; r++) na[r] = m_age[r];
      if (STICKY) begin
         for (int k = 0; k < 40; k++) begin
            bit set_k, clr_k;
            int r;
            r = k / 5;
            set_k = bus.kbd_stb && bus.kbd_in[k];
            clr_k = !nm[k] && ((bus.fe_rd_stb && !bus.zah[r]) || m_age[r] == SF);
            ns[k] = set_k || (m_stk[k] && !clr_k);
         end
         for (int r = 0; r < 8; r++) begin
            bit any;
            any = 1'b0;
            for (int b = 0; b < 5; b++)
               if (bus.kbd_stb && bus.kbd_in[5*r+b]) any = 1'b1;
            if (any) na[r] = 0;
            else if (bus.int_stb && m_age[r] < SF) na[r] = m_age[r] + 1;
         end
      end
      if (bus.mus_xstb)   m_x = bus.mus_in;
      if (bus.mus_ystb)   m_y = bus.mus_in;
      if (bus.mus_btnstb) m_b = bus.mus_in;
      if (bus.kj_stb)     m_j = bus.mus_in;
      m_mat = nm;
      m_stk = ns;
      m_kbd = nk;
      for (int r = 0; r < 8; r++) m_age[r] = na[r];
   endtask

   task automatic clear_strobes();
      bus.kbd_stb = 0; bus.mus_xstb = 0; bus.mus_ystb = 0;
      bus.mus_btnstb = 0; bus.kj_stb = 0; bus.fe_rd_stb = 0; bus.int_stb = 0;
   endtask

   // one clock: model follows the edge, strobes are dropped afterwards
   task automatic tick();
      @(posedge fclk);
      model_step();
      #1;
      clear_strobes();
   endtask

   task automatic do_reset();
      @(negedge fclk);
      rst_n = 1'b0;
      clear_strobes();
      bus.kbd_in = '0; bus.mus_in = '0; bus.zah = 8'hFF;
      model_reset();
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      tick(); tick();
      tests++;
      if (bus.kbd_data !== 5'h1F) begin
         fails++; $display("FAIL reset kbd_data got %h want 1F", bus.kbd_data);
      end
      tests++;
      if (bus.mus_btns !== 8'hFF) begin
         fails++; $display("FAIL reset mus_btns got %h want FF", bus.mus_btns);
      end
      tests++;
      if ({bus.mus_xdata, bus.mus_ydata, bus.kj_data} !== 24'h0) begin
         fails++;
         $display("FAIL reset x/y/kj got %h %h %h want 00", bus.mus_xdata,
                  bus.mus_ydata, bus.kj_data);
      end
   endtask

   task automatic test_kbd_basic();
      do_reset();
      bus.kbd_in = 40'h1; bus.kbd_stb = 1; bus.zah = 8'hFE;
      tick(); tick();
      tests++;
      if (bus.kbd_data !== 5'h1E || m_kbd !== 5'h1E) begin
         fails++; $display("FAIL kbd_row0 got %h want 1E", bus.kbd_data);
      end
      bus.zah = 8'hFD;
      tick();
      tests++;
      if (bus.kbd_data !== 5'h1F) begin
         fails++; $display("FAIL kbd_row1 got %h want 1F", bus.kbd_data);
      end
      bus.kbd_in = 40'h80_0000_0421; bus.kbd_stb = 1; bus.zah = 8'h00;
      tick(); tick();
      tests++;
      if (bus.kbd_data !== m_kbd) begin
         fails++; $display("FAIL kbd_allrows got %h want %h", bus.kbd_data, m_kbd);
      end
   endtask

   task automatic test_sticky_read();
      bit [4:0] exp;
      do_reset();
      bus.kbd_in = 40'h80; bus.kbd_stb = 1;
      tick();
      bus.kbd_in = 40'h0; bus.kbd_stb = 1;
      tick();
      bus.zah = 8'hFD;
      tick(); tick();
      exp = STICKY ? 5'h1B : 5'h1F;
      tests++;
      if (bus.kbd_data !== exp) begin
         fails++; $display("FAIL sticky_held got %h want %h", bus.kbd_data, exp);
      end
      bus.fe_rd_stb = 1;
      tick(); tick();
      tests++;
      if (bus.kbd_data !== 5'h1F) begin
         fails++; $display("FAIL sticky_read_clear got %h want 1F", bus.kbd_data);
      end
   endtask

   task automatic test_sticky_expire();
      bit [4:0] exp;
      do_reset();
      bus.kbd_in = 40'h1 << 19; bus.kbd_stb = 1;
      tick();
      bus.kbd_in = 40'h0; bus.kbd_stb = 1; bus.zah = 8'hF7;
      tick();
      bus.int_stb = 1; tick();
      bus.int_stb = 1; tick();
      tick();
      exp = STICKY ? 5'h0F : 5'h1F;
      tests++;
      if (bus.kbd_data !== exp) begin
         fails++; $display("FAIL expire_before got %h want %h", bus.kbd_data, exp);
      end
      bus.int_stb = 1; tick();
      tick(); tick(); tick();
      tests++;
      if (bus.kbd_data !== 5'h1F || bus.kbd_data !== m_kbd) begin
         fails++; $display("FAIL expire_after got %h want 1F", bus.kbd_data);
      end
   endtask

   task automatic test_simul_load_read();
      bit [4:0] exp;
      do_reset();
      bus.kbd_in = 40'h1; bus.kbd_stb = 1; bus.fe_rd_stb = 1; bus.zah = 8'h00;
      tick(); tick();
      tests++;
      if (bus.kbd_data !== 5'h1E) begin
         fails++; $display("FAIL simul_load got %h want 1E", bus.kbd_data);
      end
      bus.kbd_in = 40'h0; bus.kbd_stb = 1; bus.zah = 8'hFE;
      tick(); tick();
      exp = STICKY ? 5'h1E : 5'h1F;
      tests++;
      if (bus.kbd_data !== exp) begin
         fails++; $display("FAIL simul_sticky_kept got %h want %h", bus.kbd_data, exp);
      end
   endtask

   task automatic test_mouse();
      do_reset();
      bus.mus_in = 8'h5A; bus.mus_xstb = 1;   tick();
      bus.mus_in = 8'hA5; bus.mus_ystb = 1;   tick();
      bus.mus_in = 8'hFC; bus.mus_btnstb = 1; tick();
      bus.mus_in = 8'h10; bus.kj_stb = 1;     tick();
      tests++;
      if ({bus.mus_xdata, bus.mus_ydata, bus.mus_btns, bus.kj_data} !== 32'h5AA5FC10) begin
         fails++;
         $display("FAIL mouse_loads got %h %h %h %h want 5A A5 FC 10", bus.mus_xdata,
                  bus.mus_ydata, bus.mus_btns, bus.kj_data);
      end
      bus.mus_in = 8'h3C; bus.mus_xstb = 1; bus.kj_stb = 1;
      tick();
      tests++;
      if ({bus.mus_xdata, bus.mus_ydata, bus.kj_data} !== 24'h3CA53C) begin
         fails++;
         $display("FAIL mouse_multi got %h %h %h want 3C A5 3C", bus.mus_xdata,
                  bus.mus_ydata, bus.kj_data);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         bit [63:0] a, b;
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         bus.kbd_in = 40'(a & b & {$urandom, $urandom});
         bus.kbd_stb = ($urandom_range(0, 3) == 0);
         bus.fe_rd_stb = ($urandom_range(0, 5) == 0);
         bus.int_stb = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0: bus.zah = 8'hFF;
            1: bus.zah = 8'h00;
            default: bus.zah = 8'($urandom);
         endcase
         bus.mus_in = 8'($urandom);
         bus.mus_xstb = ($urandom_range(0, 3) == 0);
         bus.mus_ystb = ($urandom_range(0, 3) == 0);
         bus.mus_btnstb = ($urandom_range(0, 3) == 0);
         bus.kj_stb = ($urandom_range(0, 3) == 0);
         tick();
         tests++;
         if (bus.kbd_data !== m_kbd) begin
            fails++;
            $display("FAIL rand_kbd cyc %0d got %h want %h", i, bus.kbd_data, m_kbd);
         end
         tests++;
         if ({bus.mus_xdata, bus.mus_ydata, bus.mus_btns, bus.kj_data} !==
             {m_x, m_y, m_b, m_j}) begin
            fails++;
            $display("FAIL rand_mouse cyc %0d got %h%h%h%h want %h%h%h%h", i,
                     bus.mus_xdata, bus.mus_ydata, bus.mus_btns, bus.kj_data,
                     m_x, m_y, m_b, m_j);
         end
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      bus.kbd_in = 40'hFF_FFFF_FFFF; bus.kbd_stb = 1; bus.zah = 8'h00;
      bus.mus_in = 8'h77; bus.mus_xstb = 1; bus.mus_btnstb = 1;
      tick(); tick();
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({bus.kbd_data, bus.mus_xdata, bus.mus_btns} !== {5'h1F, 8'h00, 8'hFF}) begin
         fails++;
         $display("FAIL midop_reset got %h %h %h want 1F 00 FF", bus.kbd_data,
                  bus.mus_xdata, bus.mus_btns);
      end
      model_reset();
      bus.kbd_stb = 0;
      #1;
      rst_n = 1'b1;
      tick(); tick();
      tests++;
      if (bus.kbd_data !== 5'h1F) begin
         fails++; $display("FAIL midop_state_cleared got %h want 1F", bus.kbd_data);
      end
   endtask

   initial begin
      clear_strobes();
      bus.kbd_in = '0; bus.mus_in = '0; bus.zah = 8'hFF;
      test_reset();
      test_kbd_basic();
      test_sticky_read();
      test_sticky_expire();
      test_simul_load_read();
      test_mouse();
      test_random();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
